// File: rtl/control_sequencer_if.sv
// ----------------------------------------------------------------------------
// control_sequencer_if
// Connects the hardwired control sequencer to the single-bus datapath and to
// the register select-and-encode logic.
//   IR, Stop               : datapath -> sequencer (instruction word, halt request)
//   PCout/Zlowout/MDRout   : bus drive enables
//   MARin/Zin/PCin/MDRin/
//   IRin/Yin               : register load enables
//   IncPC, Read            : ALU PC+1 request, memory read strobe
//   Gra/Grb/Grc, Rin/Rout  : GPR field select and load/drive
//   alu_op                 : ALU operation code
//   Run, Illegal,
//   Instr_count            : status
// Modports: master = sequencer side, slave = datapath side.
// ----------------------------------------------------------------------------
interface control_sequencer_if #(
  parameter int IR_WIDTH     = 32,
  parameter int ALU_OP_WIDTH = 5,
  parameter int ICOUNT_WIDTH = 16
);
  logic [IR_WIDTH-1:0]     IR;
  logic                    Stop;
  logic                    PCout, Zlowout, MDRout;
  logic                    MARin, Zin, PCin, MDRin, IRin, Yin;
  logic                    IncPC, Read;
  logic                    Gra, Grb, Grc, Rin, Rout;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    Run, Illegal;
  logic [ICOUNT_WIDTH-1:0] Instr_count;

  modport master (
    input  IR, Stop,
    output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op,
           Run, Illegal, Instr_count
  );

  modport slave (
    output IR, Stop,
    input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
           IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op,
           Run, Illegal, Instr_count
  );
endinterface

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
// Hardwired Moore control unit for the single-bus datapath. Sequences
// instruction fetch (T0-T2) and register-register ALU execution (T3-T5),
// decodes NOP/HALT/undefined opcodes in T3, counts retired instructions and
// honours a Stop request at instruction boundaries.
// Ports:
//   Clock   : system clock, rising edge
//   Reset_n : asynchronous active-low reset, forces state RST
//   ctl     : control_sequencer_if.master (IR/Stop in, strobes and status out)
// ----------------------------------------------------------------------------
module control_sequencer #(
  parameter int IR_WIDTH     = 32,
  parameter int ALU_OP_WIDTH = 5,
  parameter int ICOUNT_WIDTH = 16
) (
  input  logic                Clock,
  input  logic                Reset_n,
  control_sequencer_if.master ctl
);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(5'b00011);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(5'b00100);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(5'b00101);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(5'b00110);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHR  = ALU_OP_WIDTH'(5'b00111);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHL  = ALU_OP_WIDTH'(5'b01000);
  localparam logic [ALU_OP_WIDTH-1:0] OP_NOP  = ALU_OP_WIDTH'(5'b11010);
  localparam logic [ALU_OP_WIDTH-1:0] OP_HALT = ALU_OP_WIDTH'(5'b11011);

  typedef enum logic [2:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_HALT
  } state_t;

  state_t                  state_q, state_d;
  logic                    illegal_q, illegal_d;
  logic [ICOUNT_WIDTH-1:0] icount_q, icount_d;

  logic [ALU_OP_WIDTH-1:0] opcode;
  logic                    retire;
  logic                    pc_out, zlow_out, mdr_out;
  logic                    mar_in, z_in, pc_in, mdr_in, ir_in, y_in;
  logic                    inc_pc, rd;
  logic                    gra, grb, grc, r_in, r_out;
  logic [ALU_OP_WIDTH-1:0] alu_op;

  assign opcode = ctl.IR[IR_WIDTH-1 -: ALU_OP_WIDTH];

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_RST;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      icount_q  <= icount_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    icount_d  = icount_q;
    retire    = 1'b0;
    pc_out    = 1'b0;
    zlow_out  = 1'b0;
    mdr_out   = 1'b0;
    mar_in    = 1'b0;
    z_in      = 1'b0;
    pc_in     = 1'b0;
    mdr_in    = 1'b0;
    ir_in     = 1'b0;
    y_in      = 1'b0;
    inc_pc    = 1'b0;
    rd        = 1'b0;
    gra       = 1'b0;
    grb       = 1'b0;
    grc       = 1'b0;
    r_in      = 1'b0;
    r_out     = 1'b0;
    alu_op    = '0;

    unique case (state_q)
      S_RST: state_d = S_T0;
      S_T0: begin
        pc_out  = 1'b1;
        mar_in  = 1'b1;
        inc_pc  = 1'b1;
        z_in    = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        rd       = 1'b1;
        mdr_in   = 1'b1;
        state_d  = S_T2;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
            grb     = 1'b1;
            r_out   = 1'b1;
            y_in    = 1'b1;
            state_d = S_T4;
          end
          OP_HALT: begin
            // HALT retires itself but never consults Stop.
            icount_d = icount_q + 1'b1;
            state_d  = S_HALT;
          end
          OP_NOP: retire = 1'b1;
          default: begin
            retire    = 1'b1;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_T4: begin
        grc     = 1'b1;
        r_out   = 1'b1;
        z_in    = 1'b1;
        alu_op  = opcode;
        state_d = S_T5;
      end
      S_T5: begin
        zlow_out = 1'b1;
        gra      = 1'b1;
        r_in     = 1'b1;
        retire   = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RST;
    endcase

    // Instruction boundary: count the retiring instruction, then either
    // start the next fetch or park in HALT on a pending Stop.
    if (retire) begin
      icount_d = icount_q + 1'b1;
      state_d  = ctl.Stop ? S_HALT : S_T0;
    end
  end

  assign ctl.PCout       = pc_out;
  assign ctl.Zlowout     = zlow_out;
  assign ctl.MDRout      = mdr_out;
  assign ctl.MARin       = mar_in;
  assign ctl.Zin         = z_in;
  assign ctl.PCin        = pc_in;
  assign ctl.MDRin       = mdr_in;
  assign ctl.IRin        = ir_in;
  assign ctl.Yin         = y_in;
  assign ctl.IncPC       = inc_pc;
  assign ctl.Read        = rd;
  assign ctl.Gra         = gra;
  assign ctl.Grb         = grb;
  assign ctl.Grc         = grc;
  assign ctl.Rin         = r_in;
  assign ctl.Rout        = r_out;
  assign ctl.alu_op      = alu_op;
  assign ctl.Run         = (state_q != S_RST) && (state_q != S_HALT);
  assign ctl.Illegal     = illegal_q;
  assign ctl.Instr_count = icount_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  localparam int IR_WIDTH     = 32;
  localparam int ALU_OP_WIDTH = 5;
  localparam int ICOUNT_WIDTH = 16;

  logic Clock = 1'b0;
  logic Reset_n;

  control_sequencer_if #(
    .IR_WIDTH(IR_WIDTH), .ALU_OP_WIDTH(ALU_OP_WIDTH), .ICOUNT_WIDTH(ICOUNT_WIDTH)
  ) bus ();

  control_sequencer #(
    .IR_WIDTH(IR_WIDTH), .ALU_OP_WIDTH(ALU_OP_WIDTH), .ICOUNT_WIDTH(ICOUNT_WIDTH)
  ) dut (
    .Clock  (Clock),
    .Reset_n(Reset_n),
    .ctl    (bus.master)
  );

  always #5 Clock = ~Clock;

  // Strobe bit map used by the reference model.
  localparam logic [15:0] B_PCOUT   = 16'h8000;
  localparam logic [15:0] B_ZLOWOUT = 16'h4000;
  localparam logic [15:0] B_MDROUT  = 16'h2000;
  localparam logic [15:0] B_MARIN   = 16'h1000;
  localparam logic [15:0] B_ZIN     = 16'h0800;
  localparam logic [15:0] B_PCIN    = 16'h0400;
  localparam logic [15:0] B_MDRIN   = 16'h0200;
  localparam logic [15:0] B_IRIN    = 16'h0100;
  localparam logic [15:0] B_YIN     = 16'h0080;
  localparam logic [15:0] B_INCPC   = 16'h0040;
  localparam logic [15:0] B_READ    = 16'h0020;
  localparam logic [15:0] B_GRA     = 16'h0010;
  localparam logic [15:0] B_GRB     = 16'h0008;
  localparam logic [15:0] B_GRC     = 16'h0004;
  localparam logic [15:0] B_RIN     = 16'h0002;
  localparam logic [15:0] B_ROUT    = 16'h0001;

  typedef struct packed {
    logic [15:0] strb;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;
    logic [15:0] icount;
  } obs_t;

  obs_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] m_icount;
  logic        m_illegal;
  logic [15:0] step_mask [6];

  function automatic obs_t sample();
    obs_t o;
    o.strb = {bus.PCout, bus.Zlowout, bus.MDRout, bus.MARin, bus.Zin, bus.PCin,
              bus.MDRin, bus.IRin, bus.Yin, bus.IncPC, bus.Read, bus.Gra,
              bus.Grb, bus.Grc, bus.Rin, bus.Rout};
    o.alu_op  = bus.alu_op;
    o.run     = bus.Run;
    o.illegal = bus.Illegal;
    o.icount  = bus.Instr_count;
    return o;
  endfunction

  function automatic void check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got strb=%h op=%b run=%b ill=%b cnt=%h, expected strb=%h op=%b run=%b ill=%b cnt=%h",
               name, $time, act.strb, act.alu_op, act.run, act.illegal, act.icount,
               exp.strb, exp.alu_op, exp.run, exp.illegal, exp.icount);
    end
  endfunction

  function automatic void push(input logic [15:0] strb, input logic [4:0] op, input logic run);
    obs_t r;
    r.strb    = strb;
    r.alu_op  = op;
    r.run     = run;
    r.illegal = m_illegal;
    r.icount  = m_icount;
    exp_q.push_back(r);
  endfunction

  function automatic obs_t zero_obs();
    obs_t r;
    r = '0;
    return r;
  endfunction

  // Monitor: one expected record per clock cycle while the stimulus has any queued.
  always @(negedge Clock) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", sample(), e);
    end
  end

  // Runs one instruction from the T0 cycle. stop_mode: 0 none, 1 Stop held
  // into the boundary, 2 Stop pulsed during T1 only. abort_at stops pushing at
  // that step and returns (caller resets). do_force presets the counter.
  task automatic run_instr(input logic [31:0] ir, input int stop_mode,
                           input int abort_at, input bit do_force,
                           output bit halted);
    logic [4:0] op;
    bit is_alu, is_halt, is_nop;
    int n;
    op      = ir[31:27];
    is_alu  = (op >= 5'd3) && (op <= 5'd8);
    is_halt = (op == 5'd27);
    is_nop  = (op == 5'd26);
    n       = is_alu ? 6 : 4;
    halted  = 1'b0;
    bus.IR  = ir;
    if (do_force) begin
      force dut.icount_q = 16'hFFFF;
      m_icount = 16'hFFFF;
    end
    for (int c = 0; c < n; c++) begin
      if (c == abort_at) return;
      push((c == 3 && !is_alu) ? 16'h0 : step_mask[c], (c == 4) ? op : 5'd0, 1'b1);
      case (stop_mode)
        1:       bus.Stop = (c >= n - 2);
        2:       bus.Stop = (c == 1);
        default: bus.Stop = 1'b0;
      endcase
      @(posedge Clock); #2;
      if (do_force && c == 0) release dut.icount_q;
    end
    bus.Stop = 1'b0;
    m_icount = m_icount + 16'd1;
    if (!is_alu && !is_halt && !is_nop) m_illegal = 1'b1;
    halted = is_halt || (stop_mode == 1);
  endtask

  task automatic idle_halt(input int n);
    for (int i = 0; i < n; i++) begin
      push(16'h0, 5'd0, 1'b0);
      @(posedge Clock); #2;
    end
  endtask

  // Caller has already driven Reset_n low in the current cycle.
  task automatic reset_cycles(input int n);
    m_icount  = '0;
    m_illegal = 1'b0;
    push(16'h0, 5'd0, 1'b0);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #2;
      push(16'h0, 5'd0, 1'b0);
    end
    Reset_n = 1'b1;
    @(posedge Clock); #2;
  endtask

  task automatic async_reset_check(input string name);
    Reset_n = 1'b0;
    #1;
    check(name, sample(), zero_obs());
  endtask

  initial begin
    bit          h;
    logic [31:0] ir;
    logic [4:0]  op;
    int          r;

    step_mask[0] = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    step_mask[1] = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    step_mask[2] = B_MDROUT | B_IRIN;
    step_mask[3] = B_GRB | B_ROUT | B_YIN;
    step_mask[4] = B_GRC | B_ROUT | B_ZIN;
    step_mask[5] = B_ZLOWOUT | B_GRA | B_RIN;
    m_icount  = '0;
    m_illegal = 1'b0;
    Reset_n   = 1'b0;
    bus.IR    = '0;
    bus.Stop  = 1'b0;

    @(posedge Clock); #2;
    reset_cycles(3);

    // AND R4,R5,R7 then two ADDs back to back
    run_instr(32'h2A2B8000, 0, -1, 1'b0, h);
    run_instr(32'h18000000, 0, -1, 1'b0, h);
    run_instr(32'h18000000, 0, -1, 1'b0, h);

    // NOP, undefined opcode, then a valid AND with Illegal still set
    run_instr({5'b11010, 27'h0}, 0, -1, 1'b0, h);
    run_instr({5'b10101, 27'h0}, 0, -1, 1'b0, h);
    run_instr(32'h2A2B8000, 0, -1, 1'b0, h);

    // Stop pulse in T1 is ignored; Stop held into the AND boundary halts
    async_reset_check("reset_from_T0");
    reset_cycles(1);
    run_instr(32'h2A2B8000, 2, -1, 1'b0, h);
    run_instr(32'h2A2B8000, 1, -1, 1'b0, h);
    idle_halt(20);

    // HALT opcode, then a reset pulse restarts at T0
    async_reset_check("reset_from_halt");
    reset_cycles(1);
    run_instr({5'b11011, 27'h123}, 0, -1, 1'b0, h);
    idle_halt(5);
    async_reset_check("reset_from_halt_op");
    reset_cycles(0);

    // Randomized instruction stream
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) op = 5'(3 + r);
      else if (r <= 7) op = 5'd26;
      else begin
        do op = 5'($urandom_range(0, 31));
        while ((op >= 5'd3 && op <= 5'd8) || op == 5'd26 || op == 5'd27);
      end
      ir = $urandom();
      ir[31:27] = op;
      run_instr(ir, ($urandom_range(0, 3) == 0) ? 2 : 0, -1, 1'b0, h);
    end

    // Reset mid-T4, away from any clock edge
    run_instr(32'h20000000, 0, 4, 1'b0, h);
    #1;
    async_reset_check("reset_mid_T4");
    reset_cycles(2);

    // Counter wrap: preset all-ones, next retirement yields zero
    run_instr(32'h18000000, 0, -1, 1'b1, h);
    run_instr({5'b11010, 27'h0}, 0, -1, 1'b0, h);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expected records left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit for the single-bus datapath.
- Generates the register-transfer control strobes for instruction fetch (T0–T2) and for register-register ALU execution (T3–T5).
- Sits beside the datapath: consumes the IR contents, drives the datapath control inputs, and drives Gra/Grb/Grc/Rin/Rout to the select-and-encode logic.
- Also handles halt, stop and illegal-opcode reporting.

Parameters:
- IR_WIDTH, 32, instruction register width.
- ALU_OP_WIDTH, 5, width of opcode field and alu_op output.
- ICOUNT_WIDTH, 16, width of retired-instruction counter.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- IR  input  IR_WIDTH  current IR contents. Fields: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15].
- Stop  input  1  halt request, sampled at instruction boundary.
- PCout, Zlowout, MDRout  output  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin  output  1 each  register load enables.
- IncPC  output  1  ALU computes PC+1.
- Read  output  1  memory read strobe into MDR.
- Gra, Grb, Grc  output  1 each  select IR register field Ra/Rb/Rc.
- Rin, Rout  output  1 each  load/drive the selected GPR.
- alu_op  output  ALU_OP_WIDTH  ALU operation code.
- Run  output  1  high while sequencing; low in reset and halt.
- Illegal  output  1  sticky flag, set on an undefined opcode.
- Instr_count  output  ICOUNT_WIDTH  retired instructions, wraps.

Behaviour:
- Reset:
  - Reset_n low forces state RST immediately, regardless of clock.
  - All outputs are 0, including Run, Illegal, Instr_count and alu_op.
  - This holds for reset mid-instruction too: the partial instruction is abandoned and is not counted.
- Leaving reset: the first rising edge after Reset_n goes high moves RST→T0. Run=1 in every state except RST and HALT.
- Output timing: Moore outputs, each state lasts exactly one Clock; strobes are asserted for the whole cycle; every unlisted strobe is 0.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin. IR is valid from the next cycle.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, Zin, alu_op = opcode.
  - T5: Zlowout, Gra, Rin.
- Opcode set: ADD 00011, SUB 00100, AND 00101, OR 00110, SHR 00111, SHL 01000, NOP 11010, HALT 11011.
- Decode occurs in T3 from IR:
  - ALU opcode: T3→T4→T5→T0.
  - NOP: T3 asserts no strobes, then →T0.
  - HALT: T3→HALT, no strobes.
  - Any other opcode: same as NOP, and Illegal is set on the T3→T0 edge. Illegal stays set until reset.
- alu_op is 0 in every state other than T4.
- Instruction boundary: any transition into T0 from T3 or T5.
  - Instr_count increments by 1 on that edge, wrapping from all-ones to 0.
  - If Stop is 1 on that edge, go to HALT instead of T0; the instruction is still counted.
  - Stop is ignored on the RST→T0 edge and in all other states.
- HALT:
  - Entering HALT from a HALT opcode also increments Instr_count.
  - In HALT: all strobes 0, Run=0. Exit only through Reset_n.
- Total latency: 6 cycles per ALU instruction, 4 cycles per NOP.

Test Plan:
- Reset, then IR=0x2A2B8000 (AND, Ra=R4, Rb=R5, Rc=R7) after T2 -> strobe sequence T0..T5 exactly as listed, alu_op=00101 only in T4, Gra asserted in T5, Instr_count=1 at return to T0.
- Two back-to-back ADD (0x18000000 pattern) instructions -> 12 cycles, no idle cycle between T5 and T0, Instr_count=2.
- IR opcode 11010 (NOP) -> T3 has all outputs 0, next state T0, Illegal=0. Then opcode 10101 -> same path, Illegal=1 and stays 1 through a following valid AND.
- Stop=1 held during T4 of an AND -> after T5 the unit enters HALT, Run=0, all strobes 0 for 20 cycles, Instr_count=1. Stop=1 during T1 only -> ignored.
- HALT opcode 11011 -> T3→HALT, Instr_count incremented. Reset_n pulse low then high -> RST then T0 on the next edge with Run=1.
- Reset_n asserted mid-T4 (not on a clock edge) -> all outputs 0 within the same cycle, no Clock edge needed. Instr_count=0 after release. Counter preset near wrap (force 16'hFFFF) -> next retired instruction gives 0.
